// File: rtl/config_params_cast_emitter.sv
// rtl/config_params_cast_emitter.sv - emits one parameter packet per cast/lane-enabled slot of a configuration
//
// Ports:
//   ap_clk, areset            clock (rising edge) and asynchronous active-low reset
//   cfg_valid / cfg_ready     configuration handshake; cfg_* carries per-slot masks, params and ids
//   out_valid / out_ready     packet handshake; out_* describes the emitted slot
//   out_last                  final packet of the current configuration
//   done_pulse                one-cycle pulse when a configuration completes
//   emit_count                packets handed off since reset (wraps)
module config_params_cast_emitter #(
  parameter int MASK_WIDTH  = 8,
  parameter int PARAM_WIDTH = 64,
  parameter int ID_WIDTH    = 4,
  localparam int IDX_WIDTH  = (MASK_WIDTH > 1) ? $clog2(MASK_WIDTH) : 1
) (
  input  logic                             ap_clk,
  input  logic                             areset,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  input  logic [MASK_WIDTH-1:0]            cfg_cast_mask,
  input  logic [MASK_WIDTH-1:0]            cfg_lane_mask,
  input  logic [MASK_WIDTH*PARAM_WIDTH-1:0] cfg_param_field,
  input  logic [MASK_WIDTH*ID_WIDTH-1:0]   cfg_ops_bundle,
  input  logic [MASK_WIDTH*ID_WIDTH-1:0]   cfg_ops_lane,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [PARAM_WIDTH-1:0]           out_param,
  output logic [ID_WIDTH-1:0]              out_id_bundle,
  output logic [ID_WIDTH-1:0]              out_id_lane,
  output logic                             out_cast,
  output logic                             out_lane,
  output logic [IDX_WIDTH-1:0]             out_index,
  output logic                             out_last,
  output logic                             done_pulse,
  output logic [15:0]                      emit_count
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                            state_q, state_d;
  logic                              init_q, init_d;
  logic                              done_q, done_d;
  logic [15:0]                       count_q, count_d;
  logic [MASK_WIDTH-1:0]             pending_q, pending_d;
  logic [MASK_WIDTH-1:0]             cast_q, cast_d;
  logic [MASK_WIDTH-1:0]             lane_mask_q, lane_mask_d;
  logic [MASK_WIDTH*PARAM_WIDTH-1:0] param_q, param_d;
  logic [MASK_WIDTH*ID_WIDTH-1:0]    bundle_q, bundle_d;
  logic [MASK_WIDTH*ID_WIDTH-1:0]    ops_lane_q, ops_lane_d;

  logic [IDX_WIDTH-1:0]  sel_idx;
  logic [MASK_WIDTH-1:0] pending_clr;
  logic                  accept;
  logic                  handshake;
  logic                  is_last;

  // init_q holds cfg_ready low until the first edge after reset is released.
  assign cfg_ready   = (state_q == IDLE) && init_q;
  assign out_valid   = (state_q == EMIT);
  assign pending_clr = pending_q & (pending_q - 1'b1);
  assign is_last     = (pending_q != '0) && (pending_clr == '0);
  assign accept      = cfg_valid && cfg_ready;
  assign handshake   = out_valid && out_ready;

  // Lowest set pending bit wins: scan downward so the last hit is the smallest index.
  always_comb begin
    sel_idx = '0;
    for (int i = MASK_WIDTH - 1; i >= 0; i--) begin
      if (pending_q[i]) sel_idx = IDX_WIDTH'(i);
    end
  end

  // Outputs come only from registered slot state and read as zero when no packet is offered.
  always_comb begin
    out_index     = '0;
    out_param     = '0;
    out_id_bundle = '0;
    out_id_lane   = '0;
    out_cast      = 1'b0;
    out_lane      = 1'b0;
    out_last      = 1'b0;
    if (out_valid) begin
      out_index     = sel_idx;
      out_param     = param_q[sel_idx*PARAM_WIDTH +: PARAM_WIDTH];
      out_id_bundle = bundle_q[sel_idx*ID_WIDTH +: ID_WIDTH];
      out_id_lane   = ops_lane_q[sel_idx*ID_WIDTH +: ID_WIDTH];
      out_cast      = cast_q[sel_idx];
      out_lane      = lane_mask_q[sel_idx];
      out_last      = is_last;
    end
  end

  assign done_pulse = done_q;
  assign emit_count = count_q;

  always_comb begin
    state_d     = state_q;
    init_d      = 1'b1;
    done_d      = 1'b0;
    count_d     = count_q;
    pending_d   = pending_q;
    cast_d      = cast_q;
    lane_mask_d = lane_mask_q;
    param_d     = param_q;
    bundle_d    = bundle_q;
    ops_lane_d  = ops_lane_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cast_d      = cfg_cast_mask;
          lane_mask_d = cfg_lane_mask;
          param_d     = cfg_param_field;
          bundle_d    = cfg_ops_bundle;
          ops_lane_d  = cfg_ops_lane;
          pending_d   = cfg_cast_mask | cfg_lane_mask;
          // An empty configuration completes immediately without emitting.
          if ((cfg_cast_mask | cfg_lane_mask) != '0) state_d = EMIT;
          else                                       done_d  = 1'b1;
        end
      end
      EMIT: begin
        if (handshake) begin
          pending_d = pending_clr;
          count_d   = count_q + 16'd1;
          if (is_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge areset) begin
    if (!areset) begin
      state_q     <= IDLE;
      init_q      <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= '0;
      pending_q   <= '0;
      cast_q      <= '0;
      lane_mask_q <= '0;
      param_q     <= '0;
      bundle_q    <= '0;
      ops_lane_q  <= '0;
    end else begin
      state_q     <= state_d;
      init_q      <= init_d;
      done_q      <= done_d;
      count_q     <= count_d;
      pending_q   <= pending_d;
      cast_q      <= cast_d;
      lane_mask_q <= lane_mask_d;
      param_q     <= param_d;
      bundle_q    <= bundle_d;
      ops_lane_q  <= ops_lane_d;
    end
  end

endmodule

// File: tb/tb_config_params_cast_emitter.sv
// tb/tb_config_params_cast_emitter.sv - self-checking bench for config_params_cast_emitter
module tb_config_params_cast_emitter;
  localparam int MW = 8;
  localparam int PW = 64;
  localparam int IW = 4;

  logic              ap_clk = 1'b0;
  logic              areset = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [MW-1:0]     cfg_cast_mask = '0;
  logic [MW-1:0]     cfg_lane_mask = '0;
  logic [MW*PW-1:0]  cfg_param_field = '0;
  logic [MW*IW-1:0]  cfg_ops_bundle = '0;
  logic [MW*IW-1:0]  cfg_ops_lane = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [PW-1:0]     out_param;
  logic [IW-1:0]     out_id_bundle;
  logic [IW-1:0]     out_id_lane;
  logic              out_cast;
  logic              out_lane;
  logic [2:0]        out_index;
  logic              out_last;
  logic              done_pulse;
  logic [15:0]       emit_count;

  config_params_cast_emitter #(.MASK_WIDTH(MW), .PARAM_WIDTH(PW), .ID_WIDTH(IW)) dut (
    .ap_clk(ap_clk), .areset(areset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_cast_mask(cfg_cast_mask), .cfg_lane_mask(cfg_lane_mask),
    .cfg_param_field(cfg_param_field), .cfg_ops_bundle(cfg_ops_bundle), .cfg_ops_lane(cfg_ops_lane),
    .out_valid(out_valid), .out_ready(out_ready), .out_param(out_param),
    .out_id_bundle(out_id_bundle), .out_id_lane(out_id_lane),
    .out_cast(out_cast), .out_lane(out_lane), .out_index(out_index),
    .out_last(out_last), .done_pulse(done_pulse), .emit_count(emit_count)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int          idx;
    logic        c;
    logic        l;
    logic [63:0] p;
    logic [3:0]  b;
    logic [3:0]  ln;
  } pkt_t;

  pkt_t        mq[$];
  bit          inited = 1'b0;
  logic        exp_done = 1'b0;
  logic [15:0] exp_count = '0;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          seen_idx[$];
  int          seen_cyc[$];
  int          exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a configuration becomes an ordered list of packets, one per slot with
  // either mask bit set; handshakes pop the front; emptying the list (or an empty
  // configuration) means done on the following cycle.
  always @(posedge ap_clk or negedge areset) begin
    bit   rdy;
    bit   any;
    pkt_t p;
    if (!areset) begin
      mq.delete();
      inited    = 1'b0;
      exp_done  = 1'b0;
      exp_count = '0;
    end else begin
      rdy      = inited && (mq.size() == 0);
      exp_done = 1'b0;
      if (mq.size() != 0 && out_ready) begin
        mq.delete(0);
        exp_count = exp_count + 16'd1;
        if (mq.size() == 0) exp_done = 1'b1;
      end
      if (rdy && cfg_valid) begin
        any = 1'b0;
        for (int i = 0; i < MW; i++) begin
          if (cfg_cast_mask[i] || cfg_lane_mask[i]) begin
            p.idx = i;
            p.c   = cfg_cast_mask[i];
            p.l   = cfg_lane_mask[i];
            p.p   = cfg_param_field[i*PW +: PW];
            p.b   = cfg_ops_bundle[i*IW +: IW];
            p.ln  = cfg_ops_lane[i*IW +: IW];
            mq.push_back(p);
            any = 1'b1;
          end
        end
        if (!any) exp_done = 1'b1;
      end
      inited = 1'b1;
    end
  end

  // Compare process: every cycle, on the falling edge.
  always @(negedge ap_clk) begin
    cyc++;
    if (!areset) begin
      check("rst_cfg_ready", 64'(cfg_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_done", 64'(done_pulse), 64'd0);
      check("rst_count", 64'(emit_count), 64'd0);
    end else begin
      check("cfg_ready", 64'(cfg_ready), 64'(inited && mq.size() == 0));
      check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      check("done_pulse", 64'(done_pulse), 64'(exp_done));
      check("emit_count", 64'(emit_count), 64'(exp_count));
      if (mq.size() != 0) begin
        check("out_index", 64'(out_index), 64'(mq[0].idx));
        check("out_cast", 64'(out_cast), 64'(mq[0].c));
        check("out_lane", 64'(out_lane), 64'(mq[0].l));
        check("out_param", out_param, mq[0].p);
        check("out_id_bundle", 64'(out_id_bundle), 64'(mq[0].b));
        check("out_id_lane", 64'(out_id_lane), 64'(mq[0].ln));
        check("out_last", 64'(out_last), 64'(mq.size() == 1));
      end
      if (out_valid && out_ready) begin
        seen_idx.push_back(int'(out_index));
        seen_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge ap_clk);
      #2;
    end
  endtask

  task automatic load(input logic [7:0] cast, input logic [7:0] lane, input logic [7:0] seed);
    cfg_cast_mask = cast;
    cfg_lane_mask = lane;
    for (int i = 0; i < MW; i++) begin
      cfg_param_field[i*PW +: PW] = {seed, 24'hC0FFEE, 24'(i), 8'(i * 17)};
      cfg_ops_bundle[i*IW +: IW]  = 4'(i) ^ seed[3:0];
      cfg_ops_lane[i*IW +: IW]    = ~4'(i) ^ seed[7:4];
    end
  endtask

  task automatic offer();
    cfg_valid = 1'b1;
    tick(1);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge ap_clk);
      n++;
    end while (!done_pulse && n < budget);
    if (!done_pulse) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic check_seen(input string name, input int exp[$]);
    check({name, "_len"}, 64'(seen_idx.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < seen_idx.size(); i++)
      check({name, "_idx"}, 64'(seen_idx[i]), 64'(exp[i]));
  endtask

  initial begin
    // Reset behaviour and cfg_ready release.
    areset = 1'b0;
    tick(3);
    areset = 1'b1;
    @(negedge ap_clk);
    check("ready_before_edge", 64'(cfg_ready), 64'd0);
    @(negedge ap_clk);
    check("ready_after_edge", 64'(cfg_ready), 64'd1);
    tick(1);

    // Two cast-only slots, streaming.
    out_ready = 1'b1;
    load(8'h05, 8'h00, 8'h11);
    seen_idx.delete(); seen_cyc.delete();
    offer();
    wait_done("s1", 20);
    exp_q = {0, 2};
    check_seen("s1", exp_q);
    check("s1_count", 64'(emit_count), 64'd2);
    if (seen_cyc.size() == 2) check("s1_back_to_back", 64'(seen_cyc[1] - seen_cyc[0]), 64'd1);
    tick(1);

    // Backpressure with a dual-mask slot.
    load(8'h81, 8'h01, 8'h22);
    out_ready = 1'b0;
    seen_idx.delete(); seen_cyc.delete();
    offer();
    @(negedge ap_clk);
    check("s2_idx0", 64'(out_index), 64'd0);
    check("s2_cast0", 64'(out_cast), 64'd1);
    check("s2_lane0", 64'(out_lane), 64'd1);
    tick(2);
    out_ready = 1'b1;
    wait_done("s2", 20);
    exp_q = {0, 7};
    check_seen("s2", exp_q);
    check("s2_count", 64'(emit_count), 64'd4);
    tick(1);

    // Empty configuration.
    load(8'h00, 8'h00, 8'h33);
    offer();
    @(negedge ap_clk);
    check("s3_done", 64'(done_pulse), 64'd1);
    check("s3_valid", 64'(out_valid), 64'd0);
    check("s3_ready", 64'(cfg_ready), 64'd1);
    check("s3_count", 64'(emit_count), 64'd4);
    tick(1);

    // All eight slots at full rate.
    load(8'hF0, 8'h0F, 8'h44);
    seen_idx.delete(); seen_cyc.delete();
    offer();
    wait_done("s4", 30);
    exp_q = {0, 1, 2, 3, 4, 5, 6, 7};
    check_seen("s4", exp_q);
    check("s4_count", 64'(emit_count), 64'd12);
    if (seen_cyc.size() == 8) check("s4_span", 64'(seen_cyc[7] - seen_cyc[0]), 64'd7);
    tick(1);

    // Reset after two of four packets.
    load(8'h0F, 8'h00, 8'h55);
    seen_idx.delete(); seen_cyc.delete();
    offer();
    tick(2);
    exp_q = {0, 1};
    check_seen("s5_pre", exp_q);
    areset = 1'b0;
    #1;
    check("s5_valid_drop", 64'(out_valid), 64'd0);
    check("s5_count_clr", 64'(emit_count), 64'd0);
    tick(2);
    areset = 1'b1;
    tick(1);
    load(8'h03, 8'h00, 8'h66);
    seen_idx.delete(); seen_cyc.delete();
    offer();
    wait_done("s5", 20);
    exp_q = {0, 1};
    check_seen("s5_post", exp_q);
    check("s5_count", 64'(emit_count), 64'd2);
    tick(1);

    // cfg_valid held with changing data during EMIT.
    load(8'h06, 8'h00, 8'h77);
    seen_idx.delete(); seen_cyc.delete();
    cfg_valid = 1'b1;
    tick(1);
    load(8'h30, 8'h00, 8'h88);
    wait_done("s6a", 20);
    exp_q = {1, 2};
    check_seen("s6a", exp_q);
    seen_idx.delete(); seen_cyc.delete();
    tick(1);
    cfg_valid = 1'b0;
    wait_done("s6b", 20);
    exp_q = {4, 5};
    check_seen("s6b", exp_q);
    check("s6_count", 64'(emit_count), 64'd6);
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
